// File: rtl/seq_pkg.sv
// Shared definitions for the micro_sequencer slice.
//   seq_op_t   : 4-bit next-address instruction encoding (Am2910 set)
//   SEQ_AW     : default address / counter width
//   SEQ_DEPTH  : default subroutine/loop stack depth
//   seq_d_alt  : true for the instructions that take D from map/vector
//                sources instead of the pipeline register
package seq_pkg;

  localparam int unsigned SEQ_AW    = 12;
  localparam int unsigned SEQ_DEPTH = 5;

  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } seq_op_t;

  function automatic logic seq_d_alt(input seq_op_t op);
    return (op == JMAP) || (op == CJV);
  endfunction

endpackage

// File: rtl/seq_stack.sv
// LIFO for return addresses and loop starts.
//   clk, rst_n : clock, async active-low reset (clears pointer and storage)
//   push, pop  : one operation per cycle; push wins if both are asserted
//   clear      : empties the stack (pointer only)
//   din        : value to push
//   tos        : top of stack, 0 when empty
//   full/empty : occupancy flags
// Pushing into a full stack overwrites the top entry and keeps the pointer;
// popping an empty stack does nothing.
module seq_stack #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] tos,
  output logic          full,
  output logic          empty
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] top;

  assign top   = sp - 1'b1;
  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);
  assign tos   = empty ? '0 : mem[top];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (clear) begin
      sp <= '0;
    end else if (push) begin
      if (full) begin
        mem[top] <= din;
      end else begin
        mem[sp] <= din;
        sp      <= sp + 1'b1;
      end
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Am2910-style microprogram sequencer.
//   cp        : rising-edge clock
//   resetBar  : async active-low reset; forces Y=0 while low
//   I         : next-address instruction (seq_op_t)
//   D         : branch address / counter load value
//   ccBar     : condition, active-low; ccenBar=1 forces pass
//   rldBar    : 0 loads R from D regardless of instruction
//   ci        : incrementer carry-in, uPC <= Y + ci
//   Y         : next microaddress (combinational)
//   fullBar   : 0 when the stack is full
//   plBar, mapBar, vectBar : D source enables
module micro_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned AW    = SEQ_AW,
  parameter int unsigned DEPTH = SEQ_DEPTH
) (
  input  logic          cp,
  input  logic          resetBar,
  input  logic [3:0]    I,
  input  logic [AW-1:0] D,
  input  logic          ccBar,
  input  logic          ccenBar,
  input  logic          rldBar,
  input  logic          ci,
  output logic [AW-1:0] Y,
  output logic          fullBar,
  output logic          plBar,
  output logic          mapBar,
  output logic          vectBar
);

  seq_op_t       op;
  logic          pass;
  logic          rz;
  logic [AW-1:0] upc;
  logic [AW-1:0] r;
  logic [AW-1:0] tos;
  logic [AW-1:0] y_nxt;
  logic          stk_push;
  logic          stk_pop;
  logic          stk_clr;
  logic          stk_full;
  logic          stk_empty;
  logic          r_ld_op;
  logic          r_dec;

  assign op   = seq_op_t'(I);
  assign pass = ccenBar | ~ccBar;
  assign rz   = (r == '0);

  always_comb begin
    y_nxt    = upc;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    r_ld_op  = 1'b0;
    r_dec    = 1'b0;
    unique case (op)
      JZ: begin
        y_nxt   = '0;
        stk_clr = 1'b1;
      end
      CJS: begin
        if (pass) begin
          y_nxt    = D;
          stk_push = 1'b1;
        end
      end
      JMAP: y_nxt = D;
      CJP, CJV: begin
        if (pass) y_nxt = D;
      end
      PUSH: begin
        stk_push = 1'b1;
        r_ld_op  = pass;
      end
      JSRP: begin
        y_nxt    = pass ? D : r;
        stk_push = 1'b1;
      end
      JRP: y_nxt = pass ? D : r;
      RFCT: begin
        if (!rz) begin
          y_nxt = tos;
          r_dec = 1'b1;
        end else begin
          stk_pop = 1'b1;
        end
      end
      RPCT: begin
        if (!rz) begin
          y_nxt = D;
          r_dec = 1'b1;
        end
      end
      CRTN: begin
        if (pass) begin
          y_nxt   = tos;
          stk_pop = 1'b1;
        end
      end
      CJPP: begin
        if (pass) begin
          y_nxt   = D;
          stk_pop = 1'b1;
        end
      end
      LDCT: r_ld_op = 1'b1;
      LOOP: begin
        if (pass) stk_pop = 1'b1;
        else      y_nxt   = tos;
      end
      CONT: y_nxt = upc;
      TWB: begin
        // Counter decrements whenever nonzero; a zero counter falls through
        // to D on failure, and every exit path except "counting, failed" pops.
        r_dec = ~rz;
        if (pass) begin
          stk_pop = 1'b1;
        end else if (!rz) begin
          y_nxt = tos;
        end else begin
          y_nxt   = D;
          stk_pop = 1'b1;
        end
      end
      default: y_nxt = upc;
    endcase
  end

  assign Y       = resetBar ? y_nxt : '0;
  assign fullBar = ~stk_full;
  assign plBar   = resetBar & seq_d_alt(op);
  assign mapBar  = ~(resetBar & (op == JMAP));
  assign vectBar = ~(resetBar & (op == CJV));

  always_ff @(posedge cp or negedge resetBar) begin
    if (!resetBar) begin
      upc <= '0;
      r   <= '0;
    end else begin
      upc <= Y + {{(AW-1){1'b0}}, ci};
      if (!rldBar || r_ld_op) begin
        r <= D;
      end else if (r_dec) begin
        r <= r - 1'b1;
      end
    end
  end

  seq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (cp),
    .rst_n (resetBar),
    .push  (stk_push),
    .pop   (stk_pop & ~stk_empty),
    .clear (stk_clr),
    .din   (upc),
    .tos   (tos),
    .full  (stk_full),
    .empty (stk_empty)
  );

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios followed by
// randomized instruction streams, all compared against a queue-based model.
module tb_micro_sequencer;

  localparam int AW    = 12;
  localparam int DEPTH = 5;
  localparam int MASK  = (1 << AW) - 1;

  logic          cp = 1'b0;
  logic          resetBar;
  logic [3:0]    I;
  logic [AW-1:0] D;
  logic          ccBar, ccenBar, rldBar, ci;
  logic [AW-1:0] Y;
  logic          fullBar, plBar, mapBar, vectBar;

  always #5 cp = ~cp;

  micro_sequencer #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .cp       (cp),
    .resetBar (resetBar),
    .I        (I),
    .D        (D),
    .ccBar    (ccBar),
    .ccenBar  (ccenBar),
    .rldBar   (rldBar),
    .ci       (ci),
    .Y        (Y),
    .fullBar  (fullBar),
    .plBar    (plBar),
    .mapBar   (mapBar),
    .vectBar  (vectBar)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference state
  int m_upc;
  int m_r;
  int m_stk[$];

  function automatic int m_tos();
    return (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 0;
  endfunction

  task automatic model_clear();
    m_upc = 0;
    m_r   = 0;
    m_stk.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_y"},    32'(Y), 0);
    check({tag, "_full"}, 32'(fullBar), 1);
    check({tag, "_pl"},   32'(plBar), 0);
    check({tag, "_map"},  32'(mapBar), 1);
    check({tag, "_vect"}, 32'(vectBar), 1);
  endtask

  // Called at posedge+1; holds reset across one edge and releases at posedge+1.
  task automatic do_reset();
    resetBar = 1'b0;
    #1;
    check_reset_outputs("rst");
    check("rst_sp", 32'(dut.u_stack.sp), 0);
    @(posedge cp);
    #1;
    model_clear();
    resetBar = 1'b1;
  endtask

  // One instruction cycle: drive, check combinational outputs, clock, check state.
  task automatic step(input int op, input int d, input bit ccb, input bit ccenb,
                      input bit rldb, input bit cib);
    bit pass, rz, push, pop, clr, ld, dec;
    int ey, old_upc;
    pass = ccenb || !ccb;
    rz   = (m_r == 0);
    ey   = m_upc;
    push = 0; pop = 0; clr = 0; ld = 0; dec = 0;
    case (op)
      0:  begin ey = 0; clr = 1; end
      1:  if (pass) begin ey = d; push = 1; end
      2:  ey = d;
      3:  if (pass) ey = d;
      4:  begin push = 1; ld = pass; end
      5:  begin ey = pass ? d : m_r; push = 1; end
      6:  if (pass) ey = d;
      7:  ey = pass ? d : m_r;
      8:  if (!rz) begin ey = m_tos(); dec = 1; end else pop = 1;
      9:  if (!rz) begin ey = d; dec = 1; end
      10: if (pass) begin ey = m_tos(); pop = 1; end
      11: if (pass) begin ey = d; pop = 1; end
      12: ld = 1;
      13: if (pass) pop = 1; else ey = m_tos();
      14: ;
      15: begin
            dec = !rz;
            if (pass)      pop = 1;
            else if (!rz)  ey = m_tos();
            else begin ey = d; pop = 1; end
          end
      default: ;
    endcase

    I = 4'(op); D = AW'(d); ccBar = ccb; ccenBar = ccenb; rldBar = rldb; ci = cib;
    #2;
    check($sformatf("y_op%0d", op), 32'(Y), ey);
    check("fullbar", 32'(fullBar), (m_stk.size() == DEPTH) ? 0 : 1);
    check("plbar",   32'(plBar),   (op == 2 || op == 6) ? 1 : 0);
    check("mapbar",  32'(mapBar),  (op == 2) ? 0 : 1);
    check("vectbar", 32'(vectBar), (op == 6) ? 0 : 1);

    @(posedge cp);
    #1;
    old_upc = m_upc;
    m_upc   = (ey + int'(cib)) & MASK;
    if (clr) m_stk.delete();
    else if (push) begin
      if (m_stk.size() == DEPTH) m_stk[DEPTH - 1] = old_upc;
      else m_stk.push_back(old_upc);
    end else if (pop && m_stk.size() > 0) begin
      void'(m_stk.pop_back());
    end
    if (!rldb || ld) m_r = d & MASK;
    else if (dec)    m_r = m_r - 1;

    check("upc", 32'(dut.upc), m_upc);
    check("r",   32'(dut.r),   m_r);
    check("sp",  32'(dut.u_stack.sp), m_stk.size());
    check("tos", 32'(dut.tos), m_tos());
  endtask

  initial begin
    int op, d;
    resetBar = 1'b0;
    I = 4'd14; D = '0; ccBar = 1'b1; ccenBar = 1'b1; rldBar = 1'b1; ci = 1'b1;
    model_clear();
    #1;
    check_reset_outputs("por");
    @(posedge cp);
    #1;
    resetBar = 1'b1;

    // CONT x3 from reset
    for (int k = 0; k < 3; k++) step(14, 0, 1, 1, 1, 1);
    check("cont_upc3", 32'(dut.upc), 3);
    step(14, 0, 1, 1, 1, 1);
    step(14, 0, 1, 1, 1, 1);

    // Subroutine call and return at uPC=5
    step(1, 'h100, 0, 0, 1, 1);
    check("cjs_tos", 32'(dut.tos), 5);
    step(10, 0, 0, 0, 1, 1);
    check("crtn_upc", 32'(dut.upc), 6);
    check("crtn_sp", 32'(dut.u_stack.sp), 0);

    // Counted repeat
    step(12, 3, 1, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(9, 'h40, 1, 0, 1, 1);
    check("rpct_r", 32'(dut.r), 0);

    // Stack overflow and drain
    for (int k = 0; k < 6; k++) step(4, 'h7, 1, 0, 1, 1);
    check("full_after6", 32'(fullBar), 0);
    for (int k = 0; k < 5; k++) step(10, 0, 0, 0, 1, 1);
    step(10, 0, 0, 0, 1, 1);   // pop on empty: TOS reads 0

    // Condition forcing
    step(3, 'h2aa, 1, 1, 1, 1);
    step(3, 'h2bb, 1, 0, 1, 1);

    // Two-way branch with counter
    step(4, 0, 1, 0, 1, 1);
    step(12, 2, 1, 0, 1, 1);
    step(15, 'h333, 1, 0, 1, 1);
    step(15, 'h333, 0, 0, 1, 1);
    step(4, 0, 1, 0, 1, 1);
    step(15, 'h155, 1, 0, 1, 1);   // R=0, fail -> D, pop

    // Async reset in the middle of a TWB loop
    step(4, 0, 1, 0, 1, 1);
    step(4, 0, 1, 0, 1, 1);
    step(12, 2, 1, 0, 1, 1);
    I = 4'd15; D = 12'h123; ccBar = 1'b1; ccenBar = 1'b0; rldBar = 1'b1; ci = 1'b1;
    #2;
    check("twb_pre_rst_y", 32'(Y), m_tos());
    resetBar = 1'b0;
    #1;
    check_reset_outputs("mid");
    check("mid_sp",  32'(dut.u_stack.sp), 0);
    check("mid_r",   32'(dut.r), 0);
    check("mid_upc", 32'(dut.upc), 0);
    @(posedge cp);
    #1;
    model_clear();
    resetBar = 1'b1;
    I = 4'd14;
    #1;
    check("post_rst_y", 32'(Y), 0);
    step(14, 0, 1, 1, 1, 1);

    // Map / vector source selects and the remaining branches
    step(2, 'h3c0, 1, 0, 1, 1);
    step(6, 'h0f0, 0, 0, 1, 1);
    step(6, 'h0f1, 1, 0, 1, 0);
    step(12, 'h77, 1, 0, 1, 1);
    step(7, 'h500, 1, 0, 1, 1);
    step(5, 'h600, 1, 0, 1, 1);
    step(13, 0, 1, 0, 1, 1);
    step(13, 0, 0, 0, 1, 1);
    step(11, 'h222, 0, 0, 1, 1);
    step(0, 'h111, 1, 1, 0, 1);
    step(14, 'hfff, 1, 0, 0, 1);
    step(3, 'hfff, 0, 0, 1, 1);   // uPC wraps to 0

    // Randomized stream
    for (int n = 0; n < 600; n++) begin
      if (n % 97 == 96) do_reset();
      op = int'($urandom_range(0, 15));
      d  = int'($urandom) & MASK;
      if (op == 12 || op == 4) d = int'($urandom_range(0, 4));
      step(op, d, 1'($urandom), 1'($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
